// File: rtl/arbiter_pkg.sv
// Shared types for the round-robin arbiter slice.
// Ports: none (package only).
// Provides the arbiter state encoding and a saturating-increment helper.
package arbiter_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Saturating increment used by the hold counter; width-agnostic via 32-bit math.
  function automatic int unsigned sat_inc(input int unsigned val, input int unsigned max_val);
    if (val >= max_val) begin
      return max_val;
    end
    return val + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder: finds the first set request after
// position i_last (wrapping modulo NUM_REQ), ignoring bits set in i_excl.
// Ports: i_req, i_last, i_excl in; o_found, o_onehot, o_idx out. Zero latency.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDW-1:0]     i_last,
  input  logic [NUM_REQ-1:0] i_excl,
  output logic               o_found,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IDW-1:0]     o_idx
);

  logic [NUM_REQ-1:0] w_req_eff;
  int                 w_pos;
  logic [IDW-1:0]     w_pos_idx;

  assign w_req_eff = i_req & ~i_excl;

  // Walk last+1 .. last+NUM_REQ; the last step revisits 'last' itself so the
  // most recent grantee is the lowest-priority candidate, not excluded.
  always_comb begin
    o_found   = 1'b0;
    o_onehot  = '0;
    o_idx     = '0;
    w_pos     = 0;
    w_pos_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_pos = int'(i_last) + k;
      if (w_pos >= NUM_REQ) begin
        w_pos = w_pos - NUM_REQ;
      end
      w_pos_idx = w_pos[IDW-1:0];
      if (!o_found && w_req_eff[w_pos_idx]) begin
        o_found             = 1'b1;
        o_idx               = w_pos_idx;
        o_onehot            = '0;
        o_onehot[w_pos_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// N-way round-robin grant arbiter with registered one-hot grant, zero-bubble
// hand-off between pending requesters and an optional hold limit.
// Ports: clock, reset (sync, active-high), req[NUM_REQ] in;
//        gnt[NUM_REQ], gnt_valid, gnt_id[IDW], preempt out (all registered).
// Optional feature macro: HOLD_LIMIT_EN (forced hand-off after MAX_HOLD cycles).
module rr_arbiter
  import arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       gnt_valid,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       preempt
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_REQ - 1);

  arb_state_t         r_state;
  logic [IDW-1:0]     r_last;
  logic [NUM_REQ-1:0] r_gnt;
  logic [IDW-1:0]     r_gnt_id;
  logic               r_gnt_valid;
  logic               r_preempt;

  logic               w_found;
  logic [NUM_REQ-1:0] w_pick_oh;
  logic [IDW-1:0]     w_pick_id;
  logic               w_req_g;

  // The current grantee is masked out of the search. When its req is low this
  // changes nothing; when a hold limit forces a hand-off it guarantees the
  // grant actually moves to someone else.
  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .i_req    (req),
    .i_last   (r_last),
    .i_excl   (r_gnt),
    .o_found  (w_found),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_id)
  );

  assign w_req_g = |(req & r_gnt);

`ifdef HOLD_LIMIT_EN
  localparam int HCW = $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_MAX  = HCW'(MAX_HOLD);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

  logic [HCW-1:0] r_hold_cnt;
  logic           w_at_limit;
  logic [HCW-1:0] w_hold_inc;

  // r_hold_cnt holds the number of completed grant cycles before the current
  // one, so at the edge closing the MAX_HOLD-th cycle it equals MAX_HOLD-1.
  assign w_at_limit = (r_hold_cnt >= HOLD_LAST);
  assign w_hold_inc = HCW'(sat_inc(32'(r_hold_cnt), 32'(HOLD_MAX)));
`else
  // MAX_HOLD has no effect in this build.
  logic w_unused_hold;
  assign w_unused_hold = (MAX_HOLD != 0);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ARB_IDLE;
      r_last      <= LAST_RST;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_preempt   <= 1'b0;
`ifdef HOLD_LIMIT_EN
      r_hold_cnt  <= '0;
`endif
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_found) begin
            r_state     <= ARB_GRANT;
            r_last      <= w_pick_id;
            r_gnt       <= w_pick_oh;
            r_gnt_id    <= w_pick_id;
            r_gnt_valid <= 1'b1;
`ifdef HOLD_LIMIT_EN
            r_hold_cnt  <= '0;
`endif
          end
        end

        ARB_GRANT: begin
          if (w_req_g) begin
`ifdef HOLD_LIMIT_EN
            if (w_at_limit && w_found) begin
              r_last      <= w_pick_id;
              r_gnt       <= w_pick_oh;
              r_gnt_id    <= w_pick_id;
              r_gnt_valid <= 1'b1;
              r_preempt   <= 1'b1;
              r_hold_cnt  <= '0;
            end else begin
              // Sole requester past the limit keeps the grant; count saturates.
              r_hold_cnt <= w_hold_inc;
            end
`endif
          end else if (w_found) begin
            // Zero-bubble hand-off to the next pending requester.
            r_last      <= w_pick_id;
            r_gnt       <= w_pick_oh;
            r_gnt_id    <= w_pick_id;
            r_gnt_valid <= 1'b1;
`ifdef HOLD_LIMIT_EN
            r_hold_cnt  <= '0;
`endif
          end else begin
            r_state     <= ARB_IDLE;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
`ifdef HOLD_LIMIT_EN
            r_hold_cnt  <= '0;
`endif
          end
        end

        default: begin
          r_state     <= ARB_IDLE;
          r_gnt       <= '0;
          r_gnt_id    <= '0;
          r_gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_gnt_valid;
  assign gnt_id    = r_gnt_id;
  assign preempt   = r_preempt;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed-vector bench for rr_arbiter (NUM_REQ=4, MAX_HOLD=4). Each step
// drives req/reset for one edge and queues the outputs expected after it;
// a negedge monitor pops the queue and compares.
module tb_rr_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req   = 4'b0000;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       preempt;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       pre;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  rr_arbiter #(
    .NUM_REQ  (4),
    .MAX_HOLD (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .preempt   (preempt)
  );

  // Drive one edge worth of inputs, then queue what must be visible after it.
  task automatic step(input logic rst, input logic [3:0] rq, input logic [3:0] eg,
                      input logic [1:0] eid, input logic ep, input string nm);
    exp_t e;
    reset = rst;
    req   = rq;
    @(posedge clock);
    #1;
    e.gnt  = eg;
    e.id   = eid;
    e.pre  = ep;
    e.name = nm;
    q.push_back(e);
  endtask

  // Monitor: compares every queued expectation at the falling edge.
  initial begin
    exp_t e;
    logic [7:0] act;
    logic [7:0] req_v;
    forever begin
      @(negedge clock);
      while (q.size() > 0) begin
        e     = q.pop_front();
        act   = {gnt, gnt_id, gnt_valid, preempt};
        req_v = {e.gnt, e.id, (e.gnt != 4'b0000), e.pre};
        n_cmp++;
        if (act !== req_v) begin
          n_err++;
          $display("FAIL %s: got gnt=%b id=%0d vld=%b pre=%b, want gnt=%b id=%0d vld=%b pre=%b",
                   e.name, gnt, gnt_id, gnt_valid, preempt,
                   e.gnt, e.id, (e.gnt != 4'b0000), e.pre);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d want 0", q.size());
    $fatal(1);
  end

  initial begin
    logic [3:0] oh;
    logic [3:0] oh_next;
    logic [1:0] nx;
    logic [1:0] cur;

    // Reset with all requesting: nothing granted; requester 0 wins after release.
    step(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, "reset_c1");
    step(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, "reset_c2");
    step(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b0, "first_gnt");

    // Rotation: 3 cycles per grant, then the grantee drops for one cycle.
    for (int g = 0; g < 4; g++) begin
      oh      = 4'b0001 << g;
      nx      = 2'(g + 1);
      oh_next = 4'b0001 << nx;
      step(1'b0, 4'b1111, oh, 2'(g), 1'b0, "rot_hold");
      step(1'b0, 4'b1111, oh, 2'(g), 1'b0, "rot_hold");
      step(1'b0, ~oh, oh_next, nx, 1'b0, "rot_handoff");
    end

    // Wrap and skip: move pointer to 3, then 2 only, then 0 only.
    step(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b0, "ptr_to_3");
    step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0, "skip_to_2");
    step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b0, "wrap_to_0");

    // Reset mid-grant while 1 and 2 request: pointer back to 3, so 1 wins.
    step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0, "gnt_2");
    step(1'b1, 4'b0110, 4'b0000, 2'd0, 1'b0, "mid_reset");
    step(1'b0, 4'b0110, 4'b0010, 2'd1, 1'b0, "post_reset");

    // Idle return and regrant after exactly one idle cycle.
    step(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0, "hold_1");
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "idle_return");
    step(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0, "regrant_1");

    // A pending request dropped before service is simply forgotten.
    step(1'b0, 4'b0011, 4'b0010, 2'd1, 1'b0, "pending_0");
    step(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0, "cancel_0");
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "idle_again");

    // Simultaneous from idle with pointer at 1: search 2,3,0 picks 3.
    step(1'b0, 4'b1001, 4'b1000, 2'd3, 1'b0, "simul_pick3");
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "idle_3");

`ifdef HOLD_LIMIT_EN
    // Pointer at 3, req 0011 constant: 4 cycles each, preempt at each switch.
    step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b0, "hl_first");
    cur = 2'd0;
    for (int p = 0; p < 4; p++) begin
      oh = 4'b0001 << cur;
      for (int c = 0; c < 3; c++) begin
        step(1'b0, 4'b0011, oh, cur, 1'b0, "hl_hold");
      end
      cur = (cur == 2'd0) ? 2'd1 : 2'd0;
      oh  = 4'b0001 << cur;
      step(1'b0, 4'b0011, oh, cur, 1'b1, "hl_preempt");
    end
    // Sole requester past the limit is never revoked.
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b0, "hl_sole");
    end
`else
    // Without a hold limit the grant stays put while req is high.
    step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b0, "nohl_first");
    for (int c = 0; c < 12; c++) begin
      step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b0, "nohl_hold");
    end
    step(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0, "nohl_handoff");
`endif
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "final_idle");

    @(negedge clock);
    @(negedge clock);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d entries left, want 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
